// File: rtl/ram_regfile_ctrl.sv
// ram_regfile_ctrl
//   Register-file RAM with write enable, a registered read-first read port, an
//   auto-incrementing stream pointer, out-of-range detection and a clear
//   sequencer that sweeps every entry to zero.
//
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   ena       block enable; 0 freezes all state
//   stream    0: address from addr_in, 1: address from the stream pointer
//   addr_in   direct access address / pointer load value
//   data_in   write data
//   we        write strobe
//   re        read strobe (only advances the stream pointer)
//   load_ptr  load the stream pointer from addr_in
//   clr       start a clear sweep
//   data_out  registered read data
//   ptr_out   current stream pointer
//   busy      clear sweep in progress
//   oor       previous access address was >= DEPTH
module ram_regfile_ctrl #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 48,
  parameter int ADDR_W      = 6,
  parameter int RESET_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              stream,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  input  logic              re,
  input  logic              load_ptr,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] ptr_out,
  output logic              busy,
  output logic              oor
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ctr_reg, ctr_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              oor_reg, oor_next;
  logic [DATA_W-1:0] data_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] eff_addr;
  logic              in_range;
  logic              ptr_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  assign eff_addr     = stream ? ptr_reg : addr_in;
  assign in_range     = {1'b0, eff_addr} < DEPTH_W;
  assign ptr_in_range = {1'b0, ptr_reg} < DEPTH_W;

  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg;
    ptr_next   = ptr_reg;
    oor_next   = oor_reg;
    mem_we     = 1'b0;
    mem_waddr  = eff_addr;
    mem_wdata  = data_in;
    rd_en      = 1'b0;
    if (ena) begin
      case (state_reg)
        CLEAR: begin
          // The sweep owns the write port; user strobes are ignored.
          mem_we    = 1'b1;
          mem_waddr = ctr_reg;
          mem_wdata = '0;
          ctr_next  = ctr_reg + ADDR_W'(1);
          if (ctr_reg == LAST) begin
            state_next = IDLE;
          end
        end
        default: begin
          // A pointer load in stream mode replaces that cycle's access.
          if (!(stream && load_ptr)) begin
            rd_en    = 1'b1;
            oor_next = !in_range;
            mem_we   = we && in_range;
          end
          if (load_ptr) begin
            ptr_next = addr_in;
          end else if (stream && (we || re)) begin
            // Wrap at DEPTH; a pointer loaded beyond DEPTH also restarts at 0.
            ptr_next = (!ptr_in_range || ptr_reg == LAST) ? '0 : ptr_reg + ADDR_W'(1);
          end
          if (clr) begin
            state_next = CLEAR;
            ctr_next   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= (RESET_CLEAR != 0) ? CLEAR : IDLE;
      ctr_reg   <= '0;
      ptr_reg   <= '0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
      ptr_reg   <= ptr_next;
      oor_reg   <= oor_next;
    end
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read; sampling mem before the write lands gives read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (rd_en) begin
      data_reg <= in_range ? mem[eff_addr] : '0;
    end
  end

  assign data_out = data_reg;
  assign ptr_out  = ptr_reg;
  assign busy     = (state_reg == CLEAR);
  assign oor      = oor_reg;

endmodule

// File: tb/tb_ram_regfile_ctrl.sv
// tb_ram_regfile_ctrl
//   Scoreboard bench: each driven cycle pushes the reference model's expected
//   post-edge outputs into a queue; a monitor pops and compares on the falling
//   edge. Directed scenarios are followed by randomized traffic.
module tb_ram_regfile_ctrl;

  localparam int DW = 8;
  localparam int DP = 48;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n, ena, stream, we, re, load_ptr, clr;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW-1:0] ptr_out;
  logic          busy, oor;

  always #5 clk = ~clk;

  ram_regfile_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RESET_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stream(stream), .addr_in(addr_in),
    .data_in(data_in), .we(we), .re(re), .load_ptr(load_ptr), .clr(clr),
    .data_out(data_out), .ptr_out(ptr_out), .busy(busy), .oor(oor)
  );

  typedef struct {
    int d;
    int p;
    int b;
    int o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state: plain integers and an array of entries.
  int mem_m [DP];
  int ptr_m = 0, data_m = 0, oor_m = 0, busy_m = 0, idx_m = 0;

  task automatic model_step(input int r, input int e, input int s, input int a,
                            input int d, input int w, input int rd, input int l,
                            input int c);
    int   ea;
    int   ok;
    exp_t x;
    if (r == 0) begin
      data_m = 0; ptr_m = 0; oor_m = 0; busy_m = 1; idx_m = 0;
    end else if (e != 0) begin
      if (busy_m != 0) begin
        mem_m[idx_m] = 0;
        idx_m++;
        if (idx_m == DP) busy_m = 0;
      end else begin
        ea = (s != 0) ? ptr_m : a;
        if (!(s != 0 && l != 0)) begin
          ok     = (ea < DP) ? 1 : 0;
          data_m = (ok != 0) ? mem_m[ea] : 0;
          if (w != 0 && ok != 0) mem_m[ea] = d;
          oor_m  = (ok != 0) ? 0 : 1;
        end
        if (l != 0) ptr_m = a;
        else if (s != 0 && (w != 0 || rd != 0)) ptr_m = (ptr_m >= DP - 1) ? 0 : ptr_m + 1;
        if (c != 0) begin
          busy_m = 1; idx_m = 0;
        end
      end
    end
    x.d = data_m; x.p = ptr_m; x.b = busy_m; x.o = oor_m;
    q.push_back(x);
  endtask

  // Drive one clock cycle of stimulus and record the model's expectation.
  task automatic cycle(input int r, input int e, input int s, input int a,
                       input int d, input int w, input int rd, input int l,
                       input int c);
    @(negedge clk);
    rst_n    = 1'(r);
    ena      = 1'(e);
    stream   = 1'(s);
    addr_in  = AW'(a);
    data_in  = DW'(d);
    we       = 1'(w);
    re       = 1'(rd);
    load_ptr = 1'(l);
    clr      = 1'(c);
    @(posedge clk);
    model_step(r, e, s, a, d, w, rd, l, c);
  endtask

  task automatic idle_cycle();
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic direct_read(input int a);
    cycle(1, 1, 0, a, 0, 0, 0, 0, 0);
  endtask

  // Count cycles busy stays high while random strobes (including clr and we)
  // are thrown at the block; every sweep must last exactly DP cycles.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    #1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      cycle(1, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
      #1;
    end
    checks++;
    if (n != DP) begin
      errors++;
      $display("FAIL %s: busy cycles=%0d expected=%0d", name, n, DP);
    end else begin
      $display("busy_count %s: %0d cycles", name, n);
    end
  endtask

  // Monitor: one comparison per driven cycle.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      txn++;
      checks++;
      if (int'(data_out) != x.d || int'(ptr_out) != x.p ||
          int'(busy) != x.b || int'(oor) != x.o) begin
        errors++;
        $display("FAIL txn%0d: got data_out=%02h ptr_out=%0d busy=%0d oor=%0d expected data_out=%02h ptr_out=%0d busy=%0d oor=%0d",
                 txn, data_out, ptr_out, busy, oor, x.d, x.p, x.b, x.o);
      end else begin
        $display("txn%0d data_out=%02h ptr_out=%0d busy=%0d oor=%0d", txn, data_out, ptr_out, busy, oor);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; stream = 1'b0; addr_in = '0; data_in = '0;
    we = 1'b0; re = 1'b0; load_ptr = 1'b0; clr = 1'b0;
    for (int i = 0; i < DP; i++) mem_m[i] = 0;

    // Reset, sweep length, then every entry reads zero.
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    count_busy("reset_sweep");
    for (int i = 0; i < DP; i++) direct_read(i);
    idle_cycle();

    // Direct write with same-cycle read returns old data, new data next cycle.
    cycle(1, 1, 0, 5, 8'hA5, 1, 0, 0, 0);
    direct_read(5);
    idle_cycle();

    // Stream burst that wraps at DP.
    cycle(1, 1, 1, 46, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cycle(1, 1, 1, 0, i, 1, 0, 0, 0);
    direct_read(46); direct_read(47); direct_read(0); direct_read(1);
    idle_cycle();

    // Out-of-range write dropped, entry 2 untouched.
    cycle(1, 1, 0, 50, 8'hFF, 1, 0, 0, 0);
    direct_read(2);
    idle_cycle();

    // Clear while strobes are thrown at the block, then full readback.
    cycle(1, 1, 0, 7, 8'h3C, 1, 0, 0, 1);
    count_busy("clr_sweep");
    for (int i = 0; i < DP; i++) direct_read(i);

    // Reset at sweep cycle 20 restarts the sweep.
    cycle(1, 1, 1, 9, 8'h11, 1, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) idle_cycle();
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    count_busy("reset_mid_sweep");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0) ? 0 : 1,
            ($urandom_range(0, 7) == 0) ? 0 : 1,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 63)),
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            ($urandom_range(0, 59) == 0) ? 1 : 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
